// File: rtl/trigger_burst_gen.sv
// trigger_burst_gen: delayed train of programmable-width/period trigger pulses,
// finite (Count pulses) or free-running (Count=0) until Stop or EN drop.
module trigger_burst_gen #(
   parameter int CNT_W = 16,
   parameter int NUM_W = 16
) (
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic             EN,
   input  logic             Start,
   input  logic             Stop,
   input  logic [CNT_W-1:0] Delay,
   input  logic [CNT_W-1:0] Width,
   input  logic [CNT_W-1:0] Period,
   input  logic [NUM_W-1:0] Count,
   output logic             STrig_out,
   output logic             Busy,
   output logic             Done,
   output logic [NUM_W-1:0] Pulse_cnt
);
   typedef enum logic [1:0] {IDLE, DELAY, HIGH, LOW} state_t;
   localparam logic [CNT_W:0]   ONE_C   = {{CNT_W{1'b0}}, 1'b1};
   localparam logic [NUM_W-1:0] NUM_ONE = {{(NUM_W-1){1'b0}}, 1'b1};
   state_t           state_q, state_d;
   logic [CNT_W:0]   cnt_q, cnt_d, wm1_q, wm1_d, gm1_q, gm1_d;
   logic [NUM_W-1:0] num_q, num_d, pcnt_q, pcnt_d;
   logic             strig_q, strig_d, busy_q, busy_d, done_q, done_d;
   logic [CNT_W:0]   per_x, w_eff, p_eff;
   // One extra counter bit so W'+1 cannot overflow when Width is all-ones.
   always_comb begin
      per_x = {1'b0, Period};
      w_eff = (Width == '0) ? ONE_C : {1'b0, Width};
      p_eff = (per_x > w_eff) ? per_x : w_eff + ONE_C;
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wm1_d   = wm1_q;
      gm1_d   = gm1_q;
      num_d   = num_q;
      pcnt_d  = pcnt_q;
      done_d  = 1'b0;
      if (!EN) begin
         state_d = IDLE;
         pcnt_d  = '0;
      end else if (Stop) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (Start) begin
               wm1_d   = w_eff - ONE_C;
               gm1_d   = p_eff - w_eff - ONE_C;
               num_d   = Count;
               state_d = (Delay == '0) ? HIGH : DELAY;
               cnt_d   = (Delay == '0) ? w_eff - ONE_C : {1'b0, Delay} - ONE_C;
               pcnt_d  = (Delay == '0) ? NUM_ONE : '0;
            end
            DELAY, LOW: if (cnt_q == '0) begin
               state_d = HIGH;
               cnt_d   = wm1_q;
               pcnt_d  = pcnt_q + NUM_ONE;
            end else begin
               cnt_d = cnt_q - ONE_C;
            end
            HIGH: if (cnt_q == '0) begin
               done_d  = (num_q != '0) && (pcnt_q == num_q);
               state_d = done_d ? IDLE : LOW;
               cnt_d   = gm1_q;
            end else begin
               cnt_d = cnt_q - ONE_C;
            end
            default: state_d = IDLE;
         endcase
      end
      strig_d = (state_d == HIGH);
      busy_d  = (state_d != IDLE);
   end
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wm1_q   <= '0;
         gm1_q   <= '0;
         num_q   <= '0;
         pcnt_q  <= '0;
         strig_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wm1_q   <= wm1_d;
         gm1_q   <= gm1_d;
         num_q   <= num_d;
         pcnt_q  <= pcnt_d;
         strig_q <= strig_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end
   assign STrig_out = strig_q;
   assign Busy      = busy_q;
   assign Done      = done_q;
   assign Pulse_cnt = pcnt_q;
endmodule

// File: tb/tb_trigger_burst_gen.sv
// tb_trigger_burst_gen: vector table, hand-written corner sequences and a
// randomized run against a closed-form waveform model.
module tb_trigger_burst_gen;
   logic        clk, rst_n, en, start, stop;
   logic [15:0] dly, wid, per, cnt;
   logic        strig, busy, done;
   logic [15:0] pc;
   int          n_chk = 0, n_fail = 0;

   typedef struct {
      logic        en, start, stop;
      logic [15:0] dly, wid, per, cnt;
      logic        s, b, d;
      logic [15:0] pc;
   } vec_t;
   vec_t vecs[$];

   trigger_burst_gen #(.CNT_W(16), .NUM_W(16)) dut (
      .Clock(clk), .Reset_n(rst_n), .EN(en), .Start(start), .Stop(stop),
      .Delay(dly), .Width(wid), .Period(per), .Count(cnt),
      .STrig_out(strig), .Busy(busy), .Done(done), .Pulse_cnt(pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic s, b, d, input logic [15:0] p);
      check({tag, ".STrig"}, 32'(strig), 32'(s));
      check({tag, ".Busy"}, 32'(busy), 32'(b));
      check({tag, ".Done"}, 32'(done), 32'(d));
      check({tag, ".Pulse_cnt"}, 32'(pc), 32'(p));
   endtask

   task automatic drive(input logic e, st, sp, input logic [15:0] d, w, p, c);
      en = e; start = st; stop = sp; dly = d; wid = w; per = p; cnt = c;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void add(input logic e, st, sp, input logic [15:0] d, w, p, c,
                               input logic s, b, dn, input logic [15:0] pcv);
      vecs.push_back('{e, st, sp, d, w, p, c, s, b, dn, pcv});
   endfunction

   // closed-form reference state for the random run
   bit          m_act;
   longint      m_k, m_d, m_w, m_p, m_n, m_end;
   logic [15:0] m_pc;

   initial begin
      bit s1[12]  = '{0,0,1,1,1,0,0,1,1,1,0,0};
      bit b1[12]  = '{1,1,1,1,1,1,1,1,1,1,0,0};
      int p1[12]  = '{0,0,1,1,1,1,1,2,2,2,2,2};
      bit s2[7]   = '{1,0,1,0,1,0,0};
      bit b2[7]   = '{1,1,1,1,1,0,0};
      int p2[7]   = '{1,1,2,2,3,3,3};
      for (int r = 0; r < 2; r++)
         for (int t = 0; t < 12; t++)
            add(1, (t == 0) || (r == 1 && t == 5), 0, 2, (r == 1 && t >= 5) ? 16'd9 : 16'd3, 5, 2,
                s1[t], b1[t], t == 10, 16'(p1[t]));
      for (int t = 0; t < 7; t++)
         add(1, t == 0, 0, 0, 0, 0, 3, s2[t], b2[t], t == 5, 16'(p2[t]));
      add(1, 1, 1, 0, 0, 0, 3, 0, 0, 0, 3);

      rst_n = 1'b0;
      drive(1, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      check_all("reset", 0, 0, 0, 0);
      rst_n = 1'b1;
      tick();
      check_all("post_reset", 0, 0, 0, 0);

      foreach (vecs[i]) begin
         drive(vecs[i].en, vecs[i].start, vecs[i].stop, vecs[i].dly, vecs[i].wid, vecs[i].per, vecs[i].cnt);
         tick();
         check_all($sformatf("vec%0d", i), vecs[i].s, vecs[i].b, vecs[i].d, vecs[i].pc);
      end

      // infinite train, Stop right after the 4th rising edge
      drive(1, 1, 0, 0, 1, 4, 0);
      tick();
      drive(1, 0, 0, 0, 1, 4, 0);
      for (int e = 1; e <= 12; e++) begin
         tick();
         check($sformatf("inf.Done%0d", e), 32'(done), 0);
      end
      check_all("inf.4th", 1, 1, 0, 4);
      drive(1, 0, 1, 0, 1, 4, 0);
      tick();
      check_all("inf.stop", 0, 0, 0, 4);
      drive(1, 0, 0, 0, 1, 4, 0);
      tick();
      check_all("inf.after", 0, 0, 0, 4);

      // EN drop during the low gap
      drive(1, 1, 0, 0, 2, 6, 3);
      tick();
      drive(1, 0, 0, 0, 2, 6, 3);
      tick();
      tick();
      check_all("en.low", 0, 1, 0, 1);
      drive(0, 0, 0, 0, 2, 6, 3);
      tick();
      check_all("en.off", 0, 0, 0, 0);
      drive(1, 0, 0, 0, 2, 6, 3);
      for (int e = 0; e < 3; e++) begin
         tick();
         check_all($sformatf("en.idle%0d", e), 0, 0, 0, 0);
      end

      // asynchronous reset in the middle of a pulse
      drive(1, 1, 0, 1, 4, 5, 2);
      tick();
      drive(1, 0, 0, 1, 4, 5, 2);
      tick();
      check_all("rst.high", 1, 1, 0, 1);
      #3 rst_n = 1'b0;
      #1 check_all("rst.async", 0, 0, 0, 0);
      #2 rst_n = 1'b1;
      for (int e = 0; e < 6; e++) begin
         tick();
         check_all($sformatf("rst.idle%0d", e), 0, 0, 0, 0);
      end

      // randomized run against the model
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      m_act = 0;
      m_pc  = 0;
      for (int t = 0; t < 3000; t++) begin
         logic        r_en, r_st, r_sp, e_s, e_b, e_d;
         logic [15:0] r_d, r_w, r_p, r_c;
         longint      rel;
         r_en = ($urandom_range(0, 99) != 0);
         r_st = ($urandom_range(0, 5) == 0);
         r_sp = ($urandom_range(0, 59) == 0);
         r_d  = 16'($urandom_range(0, 6));
         r_w  = 16'($urandom_range(0, 5));
         r_p  = 16'($urandom_range(0, 8));
         r_c  = 16'($urandom_range(0, 4));
         drive(r_en, r_st, r_sp, r_d, r_w, r_p, r_c);
         tick();
         e_s = 0; e_b = 0; e_d = 0;
         if (!r_en) begin
            m_act = 0;
            m_pc  = 0;
         end else if (r_sp) begin
            m_act = 0;
         end else begin
            if (!m_act && r_st) begin
               m_act = 1;
               m_k   = t;
               m_d   = longint'(r_d);
               m_w   = (r_w == 0) ? 1 : longint'(r_w);
               m_p   = (longint'(r_p) > m_w) ? longint'(r_p) : m_w + 1;
               m_n   = longint'(r_c);
               m_end = m_k + m_d + (m_n - 1) * m_p + m_w;
            end
            if (m_act) begin
               rel = t - m_k - m_d;
               if (rel >= 0) begin
                  e_s  = (rel % m_p) < m_w;
                  m_pc = 16'(rel / m_p + 1);
               end else begin
                  m_pc = 0;
               end
               if (m_n != 0 && t == m_end) begin
                  m_act = 0;
                  e_d   = 1;
               end
               e_b = m_act;
            end
         end
         check_all($sformatf("rnd%0d", t), e_s, e_b, e_d, m_pc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/trigger_burst_gen.md
# trigger_burst_gen

Generates the single-trigger pulse train that feeds the rear-edge trigger toggler's `STrig_in`. On a `Start` command it waits a programmable delay, then emits `Count` pulses of programmable width and period. `Count`=0 means an infinite train until `Stop`. Every pulse is followed by at least one low cycle, so the downstream falling-edge detector sees one edge per pulse.

## Interface
- `CNT_W`, 16, width of `Delay`/`Width`/`Period` in clock cycles
- `NUM_W`, 16, width of `Count` and `Pulse_cnt`

Ports:
- `Clock` in 1: single system clock; all logic on the rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `EN` in 1: synchronous enable; low forces IDLE and zero outputs.
- `Start` in 1: one-cycle start request; accepted only in IDLE with `EN`=1.
- `Stop` in 1: synchronous abort; honoured in any state.
- `Delay` in CNT_W: cycles from the accepted `Start` to the first rising edge.
- `Width` in CNT_W: high cycles per pulse.
- `Period` in CNT_W: rising-to-rising spacing in cycles.
- `Count` in NUM_W: pulses per burst; 0 = infinite.
- `STrig_out` out 1: registered trigger pulse, goes to the downstream `STrig_in`.
- `Busy` out 1: burst in progress.
- `Done` out 1: one-cycle pulse when a finite burst completes normally.
- `Pulse_cnt` out NUM_W: pulses emitted in the current/last burst.

## Operation
- States: IDLE, DELAY, HIGH, LOW.
- `Delay`/`Width`/`Period`/`Count` are latched when `Start` is accepted. Later input changes have no effect until the next accepted `Start`.
- Effective width W' = max(`Width`,1). Effective period P' = `Period` if `Period` > W', else W'+1. The low gap is P'−W' ≥ 1.
- IDLE:
  - `Start`&`EN`&!`Stop` → clear `Pulse_cnt`, set `Busy`.
  - If `Delay`=0, go to HIGH; else go to DELAY.
- DELAY: hold for the latched delay, then go to HIGH.
- HIGH:
  - `STrig_out`=1 for W' cycles.
  - `Pulse_cnt` increments on the edge entering HIGH. It wraps modulo 2^NUM_W in infinite mode.
  - On completion: if this was pulse number `Count` (finite mode), go to IDLE and assert `Done`; else go to LOW.
- LOW: `STrig_out`=0 for P'−W' cycles, then go to HIGH.
- `Stop` in any non-IDLE state: IDLE next edge; `STrig_out`=0, `Busy`=0, `Done` stays 0, `Pulse_cnt` held.
- `Start` while `Busy` is ignored.
- `Start` and `Stop` in the same cycle in IDLE: `Stop` wins, block stays IDLE.
- `EN`=0: next edge → IDLE, `STrig_out`/`Busy`/`Done`=0, `Pulse_cnt` cleared.
- `EN` has priority over `Stop`; `Stop` has priority over `Start`.
- Internal counters are CNT_W+1 bits wide where needed so that P'=W'+1 cannot overflow when `Width` is all-ones.

## Timing
- Reset (`Reset_n`=0, asynchronous): state IDLE; `STrig_out`=0, `Busy`=0, `Done`=0, `Pulse_cnt`=0. No pulse is produced after release until a new `Start`.
- `Start` is sampled at edge k. `Busy`=1 after edge k. `STrig_out` first goes high after edge k+`Delay`.
- Each pulse is high for exactly W' cycles. Successive rising edges are exactly P' cycles apart.
- On the final pulse, `STrig_out` falls, `Done` goes high and `Busy` goes low, all on the same edge. `Done` lasts one cycle.
- A new `Start` is accepted in the first cycle `Busy`=0. No trailing low gap is inserted after the final pulse.
- `Stop`/`EN` sampled at edge m → outputs updated after edge m.

## Test plan
- Finite burst: `Delay`=2, `Width`=3, `Period`=5, `Count`=2, `Start` at edge 0.
  - `STrig_out` high after edges 2–4 and 7–9, low from edge 10.
  - `Done` high only after edge 10; `Busy` high after edges 0–9; `Pulse_cnt`=2.
- Degenerate values: `Delay`=0, `Width`=0, `Period`=0, `Count`=3, `Start` at edge 0.
  - High after edges 0, 2, 4, each for 1 cycle.
  - `Done` after edge 5; `Pulse_cnt`=3.
- Infinite mode: `Count`=0, `Width`=1, `Period`=4; assert `Stop` after the 4th rising edge.
  - `STrig_out` 0 and `Busy` 0 next edge; `Done` never asserted; `Pulse_cnt`=4.
- Reset mid-pulse: drop `Reset_n` during HIGH.
  - All outputs 0 immediately, before the next clock.
  - After release: no activity until `Start`.
- Ignored inputs during a burst: in the first test, pulse `Start` and change `Width` to 9 at edge 5.
  - Waveform identical to the first test.
- Priorities:
  - `Start`+`Stop` same cycle in IDLE → stays IDLE, `Busy`=0.
  - `EN`=0 mid-LOW → IDLE next edge, `Pulse_cnt`=0, no `Done`.
